// File: rtl/obi_sram_arbiter_if.sv
// Bundle of the core-side OBI instruction/data ports and the SRAM macro port
// served by obi_sram_arbiter. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives the core requests and models the SRAM.
interface obi_sram_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              instr_req_i;
  logic              instr_gnt_o;
  logic [31:0]       instr_addr_i;
  logic              instr_rvalid_o;
  logic [31:0]       instr_rdata_o;

  logic              data_req_i;
  logic              data_gnt_o;
  logic [31:0]       data_addr_i;
  logic              data_we_i;
  logic [3:0]        data_be_i;
  logic [31:0]       data_wdata_i;
  logic              data_rvalid_o;
  logic [31:0]       data_rdata_o;

  logic              sram_cs_o;
  logic              sram_we_o;
  logic [3:0]        sram_be_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_wdata_o;
  logic [31:0]       sram_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  sram_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output sram_cs_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output sram_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  sram_cs_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/obi_sram_arbiter.sv
// obi_sram_arbiter: shares one single-port synchronous SRAM (1-cycle read
// latency) between the core's instruction and data OBI ports. At most one
// grant per cycle; each port has a one-deep response pipeline.
// Optional feature macro: OBI_ARB_RR_EN -- round-robin on contention
// (default build: data port has fixed priority over instruction port).
module obi_sram_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0220_0000,
  parameter int          ADDR_W    = 14
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  obi_sram_arbiter_if.slave bus
);

`ifdef OBI_ARB_RR_EN
  typedef enum logic {GRANT_INSTR = 1'b0, GRANT_DATA = 1'b1} grant_e;
  grant_e last_grant_q;
`endif

  logic        instr_gnt;
  logic        data_gnt;
  logic        data_wins;
  logic [31:0] sel_addr;

  logic        rvalid_instr_q;
  logic        rvalid_data_q;
  logic        resp_is_write_q;
  logic [31:0] instr_rdata_q;
  logic [31:0] data_rdata_q;
  logic [31:0] instr_rdata_now;
  logic [31:0] data_rdata_now;

  // Per-cycle arbitration; grants are held low throughout reset.
  always_comb begin
    data_wins = 1'b1;
`ifdef OBI_ARB_RR_EN
    if (bus.instr_req_i) data_wins = (last_grant_q == GRANT_INSTR);
`endif
    data_gnt  = rst_ni & bus.data_req_i & data_wins;
    instr_gnt = rst_ni & bus.instr_req_i & ~data_gnt;
  end

  // Drive the SRAM from whichever port won; out-of-window addresses simply wrap.
  always_comb begin
    sel_addr         = data_gnt ? bus.data_addr_i : bus.instr_addr_i;
    bus.sram_cs_o    = instr_gnt | data_gnt;
    bus.sram_we_o    = data_gnt & bus.data_we_i;
    bus.sram_addr_o  = ADDR_W'((sel_addr - BASE_ADDR) >> 2);
    bus.sram_wdata_o = data_gnt ? bus.data_wdata_i : 32'h0;
    if (data_gnt)       bus.sram_be_o = bus.data_be_i;
    else if (instr_gnt) bus.sram_be_o = 4'hF;
    else                bus.sram_be_o = 4'h0;
    bus.instr_gnt_o  = instr_gnt;
    bus.data_gnt_o   = data_gnt;
  end

  // Read data is only live in the rvalid cycle; otherwise present the held copy.
  always_comb begin
    instr_rdata_now    = rvalid_instr_q ? bus.sram_rdata_i : instr_rdata_q;
    if (!rvalid_data_q)      data_rdata_now = data_rdata_q;
    else if (resp_is_write_q) data_rdata_now = 32'h0;
    else                     data_rdata_now = bus.sram_rdata_i;
    bus.instr_rvalid_o = rvalid_instr_q;
    bus.data_rvalid_o  = rvalid_data_q;
    bus.instr_rdata_o  = instr_rdata_now;
    bus.data_rdata_o   = data_rdata_now;
  end

  // Response pipeline and held read data; reset discards any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_instr_q  <= 1'b0;
      rvalid_data_q   <= 1'b0;
      resp_is_write_q <= 1'b0;
      instr_rdata_q   <= 32'h0;
      data_rdata_q    <= 32'h0;
    end else begin
      rvalid_instr_q  <= instr_gnt;
      rvalid_data_q   <= data_gnt;
      resp_is_write_q <= data_gnt & bus.data_we_i;
      if (rvalid_instr_q) instr_rdata_q <= instr_rdata_now;
      if (rvalid_data_q)  data_rdata_q  <= data_rdata_now;
    end
  end

`ifdef OBI_ARB_RR_EN
  // Remember the most recent winner so the other port wins the next contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        last_grant_q <= GRANT_INSTR;
    else if (instr_gnt) last_grant_q <= GRANT_INSTR;
    else if (data_gnt)  last_grant_q <= GRANT_DATA;
  end
`endif

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// Bench for obi_sram_arbiter: SRAM environment model, a reference model of
// the arbiter kept at transaction level, directed literal cases and random traffic.
module tb_obi_sram_arbiter;
  localparam int          ADDR_W = 14;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h0220_0000;
`ifdef OBI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  obi_sram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  obi_sram_arbiter #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM environment (what the DUT really talks to) and the model's own image.
  logic [31:0] mem_env [DEPTH];
  logic [31:0] mem_ref [DEPTH];

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) % DEPTH;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // SRAM: 1-cycle read latency, byte-enable writes, garbage on rdata otherwise.
  always @(posedge clk) begin
    if (bus.sram_cs_o && !bus.sram_we_o) bus.sram_rdata_i <= mem_env[bus.sram_addr_o];
    else begin
      if (bus.sram_cs_o)
        mem_env[bus.sram_addr_o] = merge(mem_env[bus.sram_addr_o], bus.sram_wdata_o, bus.sram_be_o);
      bus.sram_rdata_i <= $urandom;
    end
  end

  // Reference model state.
  bit          m_last_data;
  bit          pend_i, pend_d;
  logic [31:0] pend_i_data, pend_d_data, hold_i, hold_d;
  bit          m_gi, m_gd;
  int unsigned m_idx;

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_instr_gnt", {31'h0, bus.instr_gnt_o}, 32'h0);
      chk("rst_data_gnt", {31'h0, bus.data_gnt_o}, 32'h0);
      chk("rst_cs", {31'h0, bus.sram_cs_o}, 32'h0);
      chk("rst_instr_rvalid", {31'h0, bus.instr_rvalid_o}, 32'h0);
      chk("rst_data_rvalid", {31'h0, bus.data_rvalid_o}, 32'h0);
      chk("rst_instr_rdata", bus.instr_rdata_o, 32'h0);
      chk("rst_data_rdata", bus.data_rdata_o, 32'h0);
      pend_i = 0; pend_d = 0; hold_i = 0; hold_d = 0; m_last_data = 0;
    end else begin
      chk("instr_rvalid", {31'h0, bus.instr_rvalid_o}, {31'h0, pend_i});
      if (pend_i) hold_i = pend_i_data;
      chk("instr_rdata", bus.instr_rdata_o, hold_i);
      chk("data_rvalid", {31'h0, bus.data_rvalid_o}, {31'h0, pend_d});
      if (pend_d) hold_d = pend_d_data;
      chk("data_rdata", bus.data_rdata_o, hold_d);

      m_gi = 0; m_gd = 0;
      if (bus.instr_req_i && bus.data_req_i) begin
        if (RR && m_last_data) m_gi = 1; else m_gd = 1;
      end else begin
        m_gi = bus.instr_req_i;
        m_gd = bus.data_req_i;
      end
      chk("instr_gnt", {31'h0, bus.instr_gnt_o}, {31'h0, m_gi});
      chk("data_gnt", {31'h0, bus.data_gnt_o}, {31'h0, m_gd});
      chk("sram_cs", {31'h0, bus.sram_cs_o}, {31'h0, m_gi | m_gd});
      chk("sram_we", {31'h0, bus.sram_we_o}, {31'h0, m_gd & bus.data_we_i});
      chk("sram_be", {28'h0, bus.sram_be_o}, m_gd ? {28'h0, bus.data_be_i} : (m_gi ? 32'hF : 32'h0));

      pend_i = m_gi;
      pend_d = m_gd;
      if (m_gi) begin
        m_idx = word_of(bus.instr_addr_i);
        chk("sram_addr_i", {18'h0, bus.sram_addr_o}, m_idx);
        pend_i_data = mem_ref[m_idx];
        m_last_data = 0;
      end
      if (m_gd) begin
        m_idx = word_of(bus.data_addr_i);
        chk("sram_addr_d", {18'h0, bus.sram_addr_o}, m_idx);
        chk("sram_wdata", bus.sram_wdata_o, bus.data_wdata_i);
        if (bus.data_we_i) begin
          pend_d_data = 32'h0;
          mem_ref[m_idx] = merge(mem_ref[m_idx], bus.data_wdata_i, bus.data_be_i);
        end else pend_d_data = mem_ref[m_idx];
        m_last_data = 1;
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.instr_req_i = 0;
    bus.data_req_i  = 0;
    bus.data_we_i   = 0;
  endtask

  logic [3:0] pat_d, pat_i, exp_pat;
  int         n_gnt, n_rv;
  logic [31:0] v;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      mem_env[i] = v;
      mem_ref[i] = v;
    end
    mem_env[4] = 32'hDEAD_BEEF; mem_ref[4] = 32'hDEAD_BEEF;
    mem_env[2] = 32'h0;         mem_ref[2] = 32'h0;

    // Reset held with both ports requesting.
    bus.instr_req_i = 1; bus.instr_addr_i = BASE;
    bus.data_req_i = 1;  bus.data_addr_i = BASE; bus.data_we_i = 0;
    bus.data_be_i = 4'hF; bus.data_wdata_i = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("lit_rst_gnt", {30'h0, bus.instr_gnt_o, bus.data_gnt_o}, 32'h0);
    chk("lit_rst_cs", {31'h0, bus.sram_cs_o}, 32'h0);
    chk("lit_rst_rvalid", {30'h0, bus.instr_rvalid_o, bus.data_rvalid_o}, 32'h0);
    next_cycle(); rst_n = 1; idle();

    // Instruction read.
    next_cycle(); bus.instr_req_i = 1; bus.instr_addr_i = 32'h0220_0010;
    @(negedge clk);
    chk("lit_ird_gnt", {30'h0, bus.instr_gnt_o, bus.data_gnt_o}, 32'h2);
    chk("lit_ird_addr", {18'h0, bus.sram_addr_o}, 32'd4);
    next_cycle(); idle();
    @(negedge clk);
    chk("lit_ird_rvalid", {31'h0, bus.instr_rvalid_o}, 32'h1);
    chk("lit_ird_rdata", bus.instr_rdata_o, 32'hDEAD_BEEF);

    // Data write, then read back the merged word.
    next_cycle(); bus.data_req_i = 1; bus.data_we_i = 1; bus.data_addr_i = 32'h0220_0008;
    bus.data_be_i = 4'b0011; bus.data_wdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("lit_dwr_we", {31'h0, bus.sram_we_o}, 32'h1);
    chk("lit_dwr_be", {28'h0, bus.sram_be_o}, 32'h3);
    chk("lit_dwr_addr", {18'h0, bus.sram_addr_o}, 32'd2);
    next_cycle(); idle();
    @(negedge clk);
    chk("lit_dwr_rvalid", {31'h0, bus.data_rvalid_o}, 32'h1);
    chk("lit_dwr_rdata", bus.data_rdata_o, 32'h0);
    next_cycle(); bus.data_req_i = 1; bus.data_we_i = 0;
    next_cycle(); idle();
    @(negedge clk);
    chk("lit_drd_rdata", bus.data_rdata_o, 32'h0000_5678);

    // Contention from a fresh reset (last grant = instruction).
    next_cycle(); rst_n = 0;
    next_cycle(); rst_n = 1;
    bus.instr_req_i = 1; bus.instr_addr_i = BASE + 32'h40;
    bus.data_req_i = 1;  bus.data_addr_i = BASE + 32'h80; bus.data_we_i = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat_d[k] = bus.data_gnt_o;
      pat_i[k] = bus.instr_gnt_o;
      next_cycle();
    end
    idle();
`ifdef OBI_ARB_RR_EN
    exp_pat = 4'b0101;
`else
    exp_pat = 4'b1111;
`endif
    chk("lit_cont_data", {28'h0, pat_d}, {28'h0, exp_pat});
    chk("lit_cont_instr", {28'h0, pat_i}, {28'h0, ~exp_pat});

    // Streaming instruction fetches.
    n_gnt = 0; n_rv = 0;
    for (int k = 0; k < 9; k++) begin
      next_cycle();
      bus.instr_req_i = (k < 8);
      bus.instr_addr_i = BASE + 32'h100 + 4 * k;
      @(negedge clk);
      n_gnt += bus.instr_gnt_o;
      n_rv  += bus.instr_rvalid_o;
    end
    idle();
    chk("lit_stream_gnts", n_gnt, 32'd8);
    chk("lit_stream_rvalids", n_rv, 32'd8);

    // Address wrap past the end of the SRAM window.
    next_cycle(); bus.data_req_i = 1; bus.data_we_i = 0;
    bus.data_addr_i = BASE + DEPTH * 4 + 4;
    @(negedge clk);
    chk("lit_wrap_addr", {18'h0, bus.sram_addr_o}, 32'd1);
    next_cycle(); idle();
    @(negedge clk);
    chk("lit_wrap_rvalid", {31'h0, bus.data_rvalid_o}, 32'h1);

    // Random traffic, including occasional reset mid-transaction.
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 399) != 0);
      bus.instr_req_i = ($urandom_range(0, 2) != 0);
      bus.data_req_i  = ($urandom_range(0, 2) != 0);
      bus.instr_addr_i = ($urandom_range(0, 9) == 0) ? $urandom
                       : BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
      bus.data_addr_i  = ($urandom_range(0, 9) == 0) ? $urandom
                       : BASE + 4 * $urandom_range(0, 63) + $urandom_range(0, 3);
      bus.data_we_i    = $urandom_range(0, 1);
      bus.data_be_i    = 4'($urandom);
      bus.data_wdata_i = $urandom;
    end
    next_cycle(); rst_n = 1; idle();
    repeat (3) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
